// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: operation modes, FSM states and
// the per-pass step limit of the external right shifter.
package shift_sequencer_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned MAX_STEP   = 7;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Amount the shifter can apply this pass: remaining amount capped at MAX_STEP.
    function automatic logic [2:0] pass_step(input logic [3:0] rem);
        if (rem > 4'(MAX_STEP)) begin
            return 3'(MAX_STEP);
        end
        return rem[2:0];
    endfunction

endpackage

// File: rtl/shift_sequencer_bit_reverse8.sv
// Combinational 8-bit bit reversal; lets left shifts run on the right shifter.
module bit_reverse8 (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < 8; i++) begin
            dout[i] = din[7-i];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle front end for the external 8-bit right shift/rotate unit:
// decodes a request, drives one pass per clock and returns a registered result.
//
// Handshake: start is sampled only in IDLE; done is a one-cycle pulse with
// result/err valid in that cycle; result holds until the next done.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P = DATA_WIDTH,
    parameter int unsigned MAX_STEP_P   = MAX_STEP
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_WIDTH_P-1:0] operand,
    input  logic [7:0]              amount,
    input  logic [1:0]              mode,
    input  logic                    dir,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [DATA_WIDTH_P-1:0] result,
    output logic                    sh_a,
    output logic                    sh_c,
    output logic [2:0]              sh_s,
    output logic [DATA_WIDTH_P-1:0] sh_data,
    input  logic [DATA_WIDTH_P-1:0] sh_out,
    output logic [1:0]              dbg_state
);

    state_t     state;
    logic [7:0] work;
    logic [3:0] rem;
    logic       rev_flag;

    logic [7:0] operand_rev;
    logic [7:0] out_rev;
    logic [3:0] eff;
    logic       left_lin;
    logic [3:0] rem_next;
    logic [2:0] rot_amt;

    bit_reverse8 u_rev_in  (.din(operand), .dout(operand_rev));
    bit_reverse8 u_rev_out (.din(sh_out),  .dout(out_rev));

    assign sh_data   = work;
    assign dbg_state = state;
    assign left_lin  = dir && (mode == MODE_LOG || mode == MODE_ARI);
    assign rem_next  = rem - {1'b0, sh_s};

    // A left rotate by n is a right rotate by (8-n) mod 8; linear shifts clamp at 8.
    always_comb begin
        rot_amt = '0;
        eff     = '0;
        if (mode == MODE_ROT) begin
            rot_amt = dir ? (3'd0 - amount[2:0]) : amount[2:0];
            eff     = {1'b0, rot_amt};
        end else begin
            eff = (amount > 8'd8) ? 4'd8 : amount[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            sh_a     <= 1'b0;
            sh_c     <= 1'b0;
            sh_s     <= '0;
            result   <= '0;
            work     <= '0;
            rem      <= '0;
            rev_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a     <= (mode == MODE_ARI && !dir) || (mode == MODE_ROT);
                        sh_c     <= (mode == MODE_ROT);
                        rev_flag <= left_lin;
                        work     <= left_lin ? operand_rev : operand;
                        rem      <= eff;
                        if (mode == MODE_RSV || eff == 4'd0) begin
                            // Nothing to shift: the operand passes straight through.
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            err    <= (mode == MODE_RSV);
                            result <= operand;
                        end else begin
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                            sh_s  <= pass_step(eff);
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= sh_out;
                    rem  <= rem_next;
                    if (rem_next == 4'd0) begin
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        err    <= 1'b0;
                        sh_s   <= '0;
                        result <= rev_flag ? out_rev : sh_out;
                    end else begin
                        sh_s <= pass_step(rem_next);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    sh_s  <= '0;
                end
            endcase
        end
    end

endmodule
